// File: rtl/rom_arb_pkg.sv
// Shared types, default widths and helpers for the ROM request arbiter.
package rom_arb_pkg;

  localparam int unsigned DEF_CLIENT_AW = 23;
  localparam int unsigned DEF_SDRAM_AW  = 24;
  localparam int unsigned DEF_DATA_W    = 16;

  // slice_base works on a base vector zero-extended to MAX_CLIENTS x MAX_AW bits.
  localparam int unsigned MAX_CLIENTS = 8;
  localparam int unsigned MAX_AW      = 32;
  localparam int unsigned BASE_VEC_W  = MAX_CLIENTS * MAX_AW;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Extract slice i (each aw bits wide) of a packed base vector.
  function automatic logic [MAX_AW-1:0] slice_base(input logic [BASE_VEC_W-1:0] base,
                                                   input int unsigned           aw,
                                                   input int unsigned           i);
    logic [MAX_AW-1:0] mask;
    mask = (aw >= MAX_AW) ? '1 : ((32'd1 << aw) - 32'd1);
    return MAX_AW'(base >> (i * aw)) & mask;
  endfunction

endpackage

// File: rtl/rom_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible index at or after rr_ptr_i, wrapping.
//  eligible_i  in   NUM_CLIENTS   per-client eligibility
//  rr_ptr_i    in   IW            search start index
//  any_c_o     out  1             at least one client eligible (combinational)
//  grant_c_o   out  IW            selected index, valid when any_c_o (combinational)
module rr_pick #(
  parameter int unsigned NUM_CLIENTS = 4,
  localparam int unsigned IW = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] eligible_i,
  input  logic [IW-1:0]          rr_ptr_i,
  output logic                   any_c_o,
  output logic [IW-1:0]          grant_c_o
);

  logic [IW-1:0] idx;

  // Scan NUM_CLIENTS positions starting at the pointer; keep the first hit.
  always_comb begin
    any_c_o   = 1'b0;
    grant_c_o = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      idx = IW'((32'(rr_ptr_i) + k) % NUM_CLIENTS);
      if (!any_c_o && eligible_i[idx]) begin
        any_c_o   = 1'b1;
        grant_c_o = idx;
      end
    end
  end

endmodule

// File: rtl/rom_req_arbiter.sv
// Multi-client read arbiter for the shared SDRAM ROM port: one outstanding read at a
// time, round-robin between clients, per-client base offset, level req/valid handshake.
//  clk, reset     system clock, synchronous active-high reset
//  client_req     per-client level request
//  client_addr    packed per-client word address (stable while requesting)
//  client_valid   per-client data-ready, held until the client drops req
//  client_data    packed per-client registered read data
//  sdram_req      level read request, held until sdram_ack
//  sdram_addr     registered word address of the outstanding read
//  sdram_ack      1-cycle pulse, sdram_data valid in that cycle
//  sdram_data     read data
module rom_req_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned CLIENT_AW   = DEF_CLIENT_AW,
  parameter int unsigned SDRAM_AW    = DEF_SDRAM_AW,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter logic [NUM_CLIENTS*SDRAM_AW-1:0] BASE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        client_req,
  input  logic [NUM_CLIENTS*CLIENT_AW-1:0] client_addr,
  output logic [NUM_CLIENTS-1:0]        client_valid,
  output logic [NUM_CLIENTS*DATA_W-1:0] client_data,
  output logic                          sdram_req,
  output logic [SDRAM_AW-1:0]           sdram_addr,
  input  logic                          sdram_ack,
  input  logic [DATA_W-1:0]             sdram_data
);

  localparam int unsigned IW = $clog2(NUM_CLIENTS);

  state_e                   state_q, state_d;
  logic [IW-1:0]            grant_q, grant_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NUM_CLIENTS-1:0]   served_q, served_d;
  logic [NUM_CLIENTS-1:0]   valid_q, valid_d;
  logic [DATA_W-1:0]        data_q [NUM_CLIENTS];
  logic [DATA_W-1:0]        data_d [NUM_CLIENTS];
  logic                     sdram_req_q, sdram_req_d;
  logic [SDRAM_AW-1:0]      sdram_addr_q, sdram_addr_d;

  logic [CLIENT_AW-1:0]     addr_arr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]   eligible;
  logic                     pick_any;
  logic [IW-1:0]            pick_idx;
  logic [SDRAM_AW-1:0]      pick_base;

  // Unpack per-client address slices and repack per-client data.
  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_slices
    assign addr_arr[g] = client_addr[g*CLIENT_AW +: CLIENT_AW];
    assign client_data[g*DATA_W +: DATA_W] = data_q[g];
  end

  // A client that already received data must drop req before it is eligible again.
  assign eligible  = client_req & ~served_q;
  assign pick_base = SDRAM_AW'(slice_base(BASE_VEC_W'(BASE), SDRAM_AW, 32'(pick_idx)));

  rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_rr_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .any_c_o    (pick_any),
    .grant_c_o  (pick_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      served_q     <= '0;
      valid_q      <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      served_q     <= served_d;
      valid_q      <= valid_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) data_q[i] <= data_d[i];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    served_d     = served_q;
    valid_d      = valid_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) data_d[i] = data_q[i];

    // Dropping req retires a completed transfer and re-arms the client.
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (!client_req[i]) begin
        valid_d[i]  = 1'b0;
        served_d[i] = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d      = pick_idx;
          sdram_addr_d = pick_base + SDRAM_AW'(addr_arr[pick_idx]);
          sdram_req_d  = 1'b1;
          rr_ptr_d     = (pick_idx == IW'(NUM_CLIENTS - 1)) ? '0 : pick_idx + IW'(1);
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = IDLE;
          // Data for a client that gave up while we waited is discarded.
          if (client_req[grant_q]) begin
            data_d[grant_q]   = sdram_data;
            valid_d[grant_q]  = 1'b1;
            served_d[grant_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign client_valid = valid_q;
  assign sdram_req    = sdram_req_q;
  assign sdram_addr   = sdram_addr_q;

endmodule

// File: tb/tb_rom_req_arbiter.sv
// Self-checking bench for rom_req_arbiter with an expected-address scoreboard.
module tb_rom_req_arbiter;

  localparam int unsigned NC  = 4;
  localparam int unsigned CAW = 23;
  localparam int unsigned SAW = 24;
  localparam int unsigned DW  = 16;
  localparam logic [NC*SAW-1:0] TB_BASE = {24'hFFFFF0, 24'h300000, 24'h200000, 24'h100000};

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     creq;
  logic [CAW-1:0]    caddr [NC];
  logic [NC*CAW-1:0] client_addr;
  logic [NC-1:0]     client_valid;
  logic [NC*DW-1:0]  client_data;
  logic              sdram_req;
  logic [SAW-1:0]    sdram_addr;
  logic              sdram_ack;
  logic [DW-1:0]     sdram_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [SAW-1:0] exp_addr_q [$];

  assign client_addr = {caddr[3], caddr[2], caddr[1], caddr[0]};

  rom_req_arbiter #(
    .NUM_CLIENTS (NC),
    .CLIENT_AW   (CAW),
    .SDRAM_AW    (SAW),
    .DATA_W      (DW),
    .BASE        (TB_BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .client_req   (creq),
    .client_addr  (client_addr),
    .client_valid (client_valid),
    .client_data  (client_data),
    .sdram_req    (sdram_req),
    .sdram_addr   (sdram_addr),
    .sdram_ack    (sdram_ack),
    .sdram_data   (sdram_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] cdata(input int i);
    return client_data[i*DW +: DW];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    creq  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive a request and record the SDRAM address it must produce.
  task automatic request(input int c, input logic [CAW-1:0] a, input logic [SAW-1:0] exp_a);
    caddr[c] = a;
    creq[c]  = 1'b1;
    exp_addr_q.push_back(exp_a);
  endtask

  // Wait (bounded) for sdram_req; k counts the sampling edges taken.
  task automatic wait_req(output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!sdram_req && k < 50);
    check("req_timeout", 64'(sdram_req), 1);
    if (sdram_req) begin
      check("sb_pending", 64'(exp_addr_q.size() != 0), 1);
      if (exp_addr_q.size() != 0) check("sdram_addr", 64'(sdram_addr), 64'(exp_addr_q.pop_front()));
    end
  endtask

  // Hold for lat cycles checking req/addr stability, optionally dropping a client's req, then ack.
  task automatic do_ack(input int lat, input logic [DW-1:0] d, input int drop_client);
    logic [SAW-1:0] a0;
    int held;
    a0   = sdram_addr;
    held = 1;
    for (int c = 1; c < lat; c++) begin
      @(posedge clk); #1;
      if (c == 1 && drop_client >= 0) creq[drop_client] = 1'b0;
      if (!sdram_req || sdram_addr !== a0) held = 0;
    end
    check("req_held", 64'(held), 1);
    sdram_data = d;
    sdram_ack  = 1'b1;
    @(posedge clk); #1;
    sdram_ack  = 1'b0;
    sdram_data = '0;
    check("req_low_after_ack", 64'(sdram_req), 0);
  endtask

  initial begin
    int k;
    int cnt;
    reset      = 1'b1;
    creq       = '0;
    sdram_ack  = 1'b0;
    sdram_data = '0;
    for (int i = 0; i < NC; i++) caddr[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_sdram_req", 64'(sdram_req), 0);
    check("rst_sdram_addr", 64'(sdram_addr), 0);
    check("rst_valid", 64'(client_valid), 0);
    check("rst_data", 64'(client_data), 0);

    // 1: single read
    request(0, 23'h000123, 24'h100123);
    wait_req(k);
    check("t1_latency", 64'(k), 1);
    do_ack(5, 16'hBEEF, -1);
    check("t1_valid", 64'(client_valid), 4'b0001);
    check("t1_data", 64'(cdata(0)), 16'hBEEF);
    repeat (3) @(posedge clk);
    #1;
    check("t1_valid_hold", 64'(client_valid[0]), 1);
    check("t1_data_hold", 64'(cdata(0)), 16'hBEEF);
    creq[0] = 1'b0;
    @(posedge clk); #1;
    check("t1_valid_drop", 64'(client_valid[0]), 0);

    // 2: contention from a fresh rr_ptr
    do_reset();
    request(0, 23'h10, 24'h100010);
    request(1, 23'h20, 24'h200020);
    request(2, 23'h30, 24'h300030);
    for (int i = 0; i < 3; i++) begin
      wait_req(k);
      check("t2_reissue_gap", 64'(k), 1);
      do_ack(3, 16'((i + 1) * 16'h1111), -1);
      check("t2_valid", 64'(client_valid[i]), 1);
      check("t2_data", 64'(cdata(i)), 64'((i + 1) * 16'h1111));
    end
    check("t2_valid_all", 64'(client_valid), 4'b0111);
    creq = '0;
    @(posedge clk); #1;
    check("t2_valid_clear", 64'(client_valid), 0);

    // 3: held request is not re-served
    request(0, 23'h5, 24'h100005);
    wait_req(k);
    do_ack(4, 16'h5A5A, -1);
    check("t3_valid", 64'(client_valid[0]), 1);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sdram_req) cnt++;
    end
    check("t3_no_reissue", 64'(cnt), 0);
    check("t3_data_stable", 64'(cdata(0)), 16'h5A5A);
    creq[0] = 1'b0;
    @(posedge clk); #1;
    check("t3_valid_drop", 64'(client_valid[0]), 0);
    request(0, 23'h5, 24'h100005);
    wait_req(k);
    check("t3_rereq_latency", 64'(k), 1);
    do_ack(2, 16'h6B6B, -1);
    check("t3_data2", 64'(cdata(0)), 16'h6B6B);
    creq[0] = 1'b0;
    @(posedge clk); #1;

    // 4: abandon while busy
    request(1, 23'h40, 24'h200040);
    wait_req(k);
    do_ack(5, 16'hDEAD, 1);
    check("t4_valid1", 64'(client_valid[1]), 0);
    check("t4_data1", 64'(cdata(1)), 16'h2222);
    request(2, 23'h7, 24'h300007);
    wait_req(k);
    check("t4_idle_grant", 64'(k), 1);
    do_ack(2, 16'h7777, -1);
    check("t4_data2", 64'(cdata(2)), 16'h7777);
    creq[2] = 1'b0;
    @(posedge clk); #1;

    // 5: reset mid-read, then a stray ack
    request(2, 23'h9, 24'h300009);
    wait_req(k);
    @(posedge clk); #1;
    reset = 1'b1;
    creq  = '0;
    @(posedge clk); #1;
    check("t5_req", 64'(sdram_req), 0);
    check("t5_addr", 64'(sdram_addr), 0);
    check("t5_valid", 64'(client_valid), 0);
    check("t5_data", 64'(client_data), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    sdram_ack  = 1'b1;
    sdram_data = 16'hBAD0;
    @(posedge clk); #1;
    sdram_ack  = 1'b0;
    sdram_data = '0;
    @(posedge clk); #1;
    check("t5_stray_req", 64'(sdram_req), 0);
    check("t5_stray_valid", 64'(client_valid), 0);
    check("t5_stray_data", 64'(client_data), 0);
    request(2, 23'h9, 24'h300009);
    wait_req(k);
    check("t5_resume_latency", 64'(k), 1);
    do_ack(3, 16'h9999, -1);
    check("t5_resume_data", 64'(cdata(2)), 16'h9999);
    creq[2] = 1'b0;
    @(posedge clk); #1;

    // 6: base + address wraps modulo 2^SDRAM_AW
    request(3, 23'h20, 24'h000010);
    wait_req(k);
    do_ack(3, 16'h3C3C, -1);
    check("t6_valid3", 64'(client_valid), 4'b1000);
    check("t6_data3", 64'(cdata(3)), 16'h3C3C);
    creq[3] = 1'b0;
    @(posedge clk); #1;
    check("t6_valid_clear", 64'(client_valid), 0);
    check("sb_drained", 64'(exp_addr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
